alu_result_buffer: RTL

- Downstream stage of the ALU. Captures each ALU result (signed N-bit C plus zero flag Z) offered with a valid strobe.
- Stores results in a DEPTH-entry FIFO and releases them to the consumer over a valid/ready handshake.
- Keeps running statistics on accepted results: zero count, drop count, signed min and max.

---
 rtl/alu_result_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_buffer
// Purpose  : Downstream stage of the ALU. Captures each signed ALU result C
//            and its zero flag Z into a DEPTH-entry first-word-fall-through
//            FIFO, releases them over a valid/ready handshake and keeps
//            running statistics (zero count, drop count, signed min/max).
// Ports    : clk, rst (async, active-high)
//            in_valid/C/Z/in_ready       - producer side (ALU)
//            out_valid/out_ready/out_data/out_zero - consumer side
//            count                       - entries currently stored
//            stat_clr                    - synchronous statistics clear
//            zero_cnt/drop_cnt/max_val/min_val/stats_valid - statistics
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [N-1:0]               C,
  input  logic                       Z,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic                       out_zero,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           zero_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [N-1:0]               max_val,
  output logic [N-1:0]               min_val,
  output logic                       stats_valid
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam int                c_CW       = c_AW + 1;
  localparam logic [c_CW-1:0]   c_FULL     = c_CW'(DEPTH);
  localparam logic [N-1:0]      c_MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]      c_MOST_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  logic [N-1:0]      r_mem_data [DEPTH];
  logic [DEPTH-1:0]  r_mem_zero;
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_drop;

  // Handshake depends on registered count only, so in_ready has no path
  // from out_ready.
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = in_valid & ~in_ready;

  // First-word-fall-through: head entry read straight from storage.
  assign out_data = r_mem_data[r_rd_ptr];
  assign out_zero = r_mem_zero[r_rd_ptr];
  assign count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
      end
      r_mem_zero <= '0;
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= C;
      r_mem_zero[r_wr_ptr] <= Z;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // A clear selects the reset values as the base, and the same edge's push
  // or drop is then applied on top, so a coinciding sample is not lost.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_zero_cnt, w_zero_base, w_zero_nxt;
  logic [CNT_W-1:0] r_drop_cnt, w_drop_base, w_drop_nxt;
  logic [N-1:0]     r_max, w_max_base, w_max_nxt;
  logic [N-1:0]     r_min, w_min_base, w_min_nxt;
  logic             r_stats_valid, w_stats_valid_nxt;

  assign w_zero_base = stat_clr ? '0         : r_zero_cnt;
  assign w_drop_base = stat_clr ? '0         : r_drop_cnt;
  assign w_max_base  = stat_clr ? c_MOST_NEG : r_max;
  assign w_min_base  = stat_clr ? c_MOST_POS : r_min;

  always_comb begin
    w_zero_nxt        = w_zero_base;
    w_drop_nxt        = w_drop_base;
    w_max_nxt         = w_max_base;
    w_min_nxt         = w_min_base;
    w_stats_valid_nxt = r_stats_valid & ~stat_clr;

    if (w_push) begin
      if (Z && (w_zero_base != c_CNT_MAX)) w_zero_nxt = w_zero_base + CNT_W'(1);
      if ($signed(C) > $signed(w_max_base)) w_max_nxt = C;
      if ($signed(C) < $signed(w_min_base)) w_min_nxt = C;
      w_stats_valid_nxt = 1'b1;
    end

    if (w_drop && (w_drop_base != c_CNT_MAX)) w_drop_nxt = w_drop_base + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero_cnt    <= '0;
      r_drop_cnt    <= '0;
      r_max         <= c_MOST_NEG;
      r_min         <= c_MOST_POS;
      r_stats_valid <= 1'b0;
    end else begin
      r_zero_cnt    <= w_zero_nxt;
      r_drop_cnt    <= w_drop_nxt;
      r_max         <= w_max_nxt;
      r_min         <= w_min_nxt;
      r_stats_valid <= w_stats_valid_nxt;
    end
  end

  assign zero_cnt    = r_zero_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign max_val     = r_max;
  assign min_val     = r_min;
  assign stats_valid = r_stats_valid;

endmodule
`default_nettype wire
